// File: rtl/sevseg_pkg.sv
// Shared types and glyph table for the seven-segment scan controller.
// Patterns are active-high, bit 0 = segment a through bit 6 = segment g.
package sevseg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF_AH = 7'h00;

  localparam seg7_t HEX_PAT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg7_t seg_pol(
    input seg7_t s,
    input bit    act_low
  );
    return act_low ? ~s : s;
  endfunction

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational hex nibble to active-high seven-segment pattern.
// One instance per display digit plus one for the scan path.
module sevseg_hex_decode
  import sevseg_pkg::*;
(
  input  logic [3:0] nib,
  output seg7_t      seg
);

  assign seg = HEX_PAT[nib];

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// N-digit hex seven-segment controller: frame-synchronous commit, parallel
// and scanned outputs, blanking; blink is compiled in with SEVSEG_BLINK_EN.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int DIGITS         = 3,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 12500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic                  lz_en,
`ifdef SEVSEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic                  ready,
  output logic [7*DIGITS-1:0]   seg_par,
  output logic [6:0]            seg_scan,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);

  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  localparam seg7_t SEG_OFF = seg_pol(SEG_OFF_AH, SEG_ACTIVE_LOW);

  logic [PW-1:0]       pre;
  logic [IW-1:0]       idx;
  logic                pre_tc;
  logic                wrap;

  logic [4*DIGITS-1:0] committed;
  logic [4*DIGITS-1:0] pending_val;
  logic                pending;

  logic [DIGITS-1:0]   lz_dark;
  logic [DIGITS-1:0]   blink_dark;
  logic [DIGITS-1:0]   dark;

  logic [7*DIGITS-1:0] par_next;
  logic [3:0]          scan_nib;
  seg7_t               scan_pat;
  seg7_t               scan_next;
  logic [DIGITS-1:0]   dig_next;

  assign pre_tc = (pre == PRE_LAST);
  assign wrap   = pre_tc && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      idx <= '0;
    end else if (pre_tc) begin
      pre <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  // Old pending_val commits on the wrap even if a new load lands there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      committed   <= '0;
      pending_val <= '0;
      pending     <= 1'b0;
    end else begin
      if (wrap && pending) begin
        committed <= pending_val;
      end
      if (load) begin
        pending_val <= value;
        pending     <= 1'b1;
      end else if (wrap) begin
        pending     <= 1'b0;
      end
    end
  end

  assign ready = ~pending;

`ifdef SEVSEG_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);

  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blink_dark = blink_on ? '0 : blink_mask;
`else
  logic unused_blink_div;

  assign unused_blink_div = (BLINK_DIV > 1);
  assign blink_dark       = '0;
`endif

  // Walk down from the top digit tracking "everything at or above is 0".
  always_comb begin
    logic z;
    z       = 1'b1;
    lz_dark = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      z          = z & (committed[4*d +: 4] == 4'h0);
      lz_dark[d] = z & lz_en;
    end
    lz_dark[0] = 1'b0;
  end

  assign dark = blank_mask | lz_dark | blink_dark;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_t pat;

    sevseg_hex_decode u_dec (
      .nib (committed[4*g +: 4]),
      .seg (pat)
    );

    assign par_next[7*g +: 7] =
      seg_pol(dark[g] ? SEG_OFF_AH : pat, SEG_ACTIVE_LOW);
  end

  assign scan_nib = committed[4*idx +: 4];

  sevseg_hex_decode u_scan_dec (
    .nib (scan_nib),
    .seg (scan_pat)
  );

  assign scan_next =
    seg_pol(dark[idx] ? SEG_OFF_AH : scan_pat, SEG_ACTIVE_LOW);
  assign dig_next  = DIGITS'(1) << idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_par  <= {DIGITS{SEG_OFF}};
      seg_scan <= SEG_OFF;
      dig_en   <= '0;
    end else begin
      seg_par  <= par_next;
      seg_scan <= scan_next;
      dig_en   <= dig_next;
    end
  end

endmodule
